// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared types and constants for the memory-access stage.
//   state_t          - FSM state encoding (IDLE, ACCESS)
//   wb_ctrl_t        - MEM/WB control bits (RegWrite, MemtoReg)
//   WB_BUBBLE        - control value loaded into MEM/WB for a bubble
//   DEFAULT_MAX_WAIT - default number of ACCESS cycles before a timeout
package mem_stage_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } wb_ctrl_t;

    localparam wb_ctrl_t WB_BUBBLE = '{reg_write: 1'b0, mem_to_reg: 1'b0};

    localparam int DEFAULT_MAX_WAIT = 15;

endpackage

// File: rtl/mem_wb_reg.sv
// mem_wb_reg: MEM/WB pipeline register.
// Ports:
//   clk            clock, rising edge
//   rst_n          synchronous active-low reset, clears every field
//   bubble         1 = load an empty slot (all fields zero) instead of the inputs
//   ctrl           RegWrite / MemtoReg control to load
//   read_data      load data to load
//   alu_result     ALU result to load
//   rd_addr        destination register to load
//   wb_*           registered MEM/WB outputs
module mem_wb_reg
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bubble,
    input  wb_ctrl_t    ctrl,
    input  logic [31:0] read_data,
    input  logic [31:0] alu_result,
    input  logic [4:0]  rd_addr,
    output logic        wb_reg_write,
    output logic        wb_mem_to_reg,
    output logic [31:0] wb_read_data,
    output logic [31:0] wb_alu_result,
    output logic [4:0]  wb_rd_addr
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_reg_write  <= 1'b0;
            wb_mem_to_reg <= 1'b0;
            wb_read_data  <= '0;
            wb_alu_result <= '0;
            wb_rd_addr    <= '0;
        end else if (bubble) begin
            // A bubble is a fully zeroed slot so it can never be mistaken
            // for a real instruction downstream.
            wb_reg_write  <= WB_BUBBLE.reg_write;
            wb_mem_to_reg <= WB_BUBBLE.mem_to_reg;
            wb_read_data  <= '0;
            wb_alu_result <= '0;
            wb_rd_addr    <= '0;
        end else begin
            wb_reg_write  <= ctrl.reg_write;
            wb_mem_to_reg <= ctrl.mem_to_reg;
            wb_read_data  <= read_data;
            wb_alu_result <= alu_result;
            wb_rd_addr    <= rd_addr;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the 5-stage pipeline.
// Resolves branches combinationally, runs loads/stores against data memory
// over a req/ack handshake (stalling upstream while outstanding) and owns
// the MEM/WB register.
// Ports:
//   clk_i, rst_i                 clock; synchronous active-low reset
//   sum_i, ALUResult_i, zero_i   EX/MEM branch target, ALU result/address, zero flag
//   RTdata_i, RDaddr_i           EX/MEM store data, destination register
//   Branch_i .. MemtoReg_i       EX/MEM control bits
//   PCSrc_o, branch_target_o     branch decision and target (combinational)
//   stall_o                      freeze PC, IF/ID, ID/EX, EX/MEM (combinational)
//   mem_req_o .. mem_wdata_o     registered data-memory request
//   mem_ack_i, mem_rdata_i       memory completion and read data
//   RegWrite_o .. RDaddr_o       MEM/WB register outputs
//   err_o                        sticky error: misaligned, read+write, or timeout
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] sum_i,
    input  logic [31:0] ALUResult_i,
    input  logic        zero_i,
    input  logic [31:0] RTdata_i,
    input  logic [4:0]  RDaddr_i,
    input  logic        Branch_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic        RegWrite_i,
    input  logic        MemtoReg_i,
    output logic        PCSrc_o,
    output logic [31:0] branch_target_o,
    output logic        stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        RegWrite_o,
    output logic        MemtoReg_o,
    output logic [31:0] ReadData_o,
    output logic [31:0] ALUResult_o,
    output logic [4:0]  RDaddr_o,
    output logic        err_o
);

    // Last wait_cnt value at which an ACCESS cycle may still see its ack.
    localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

    state_t      state;
    logic [7:0]  wait_cnt;

    logic        mem_op;
    logic        illegal;
    logic        misaligned;
    logic        start;
    logic        fault;
    logic        done;
    logic        abort;
    logic        wb_bubble;
    logic [31:0] wb_rdata;
    wb_ctrl_t    wb_ctrl;

    assign PCSrc_o         = Branch_i & zero_i;
    assign branch_target_o = sum_i;

    assign mem_op     = MemRead_i ^ MemWrite_i;
    assign illegal    = MemRead_i & MemWrite_i;
    assign misaligned = mem_op & (ALUResult_i[1:0] != 2'b00);

    assign wb_ctrl = '{reg_write: RegWrite_i, mem_to_reg: MemtoReg_i};

    // Stall/bubble decisions. EX/MEM is frozen during ACCESS, so the
    // *_i inputs still describe the instruction being serviced.
    always_comb begin
        stall_o   = 1'b0;
        wb_bubble = 1'b0;
        wb_rdata  = '0;
        start     = 1'b0;
        fault     = 1'b0;
        done      = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (illegal || misaligned) begin
                    fault     = 1'b1;
                    wb_bubble = 1'b1;
                end else if (mem_op) begin
                    stall_o   = 1'b1;
                    wb_bubble = 1'b1;
                    start     = 1'b1;
                end
            end
            ACCESS: begin
                // An ack in the timeout cycle still completes the access.
                if (mem_ack_i) begin
                    done = 1'b1;
                    if (!mem_we_o) begin
                        wb_rdata = mem_rdata_i;
                    end
                end else if (wait_cnt == LAST_WAIT) begin
                    abort     = 1'b1;
                    wb_bubble = 1'b1;
                end else begin
                    stall_o   = 1'b1;
                    wb_bubble = 1'b1;
                end
            end
            default: begin
                wb_bubble = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            err_o       <= 1'b0;
        end else begin
            if (fault || abort) begin
                err_o <= 1'b1;
            end
            if (start) begin
                state       <= ACCESS;
                wait_cnt    <= '0;
                mem_req_o   <= 1'b1;
                mem_we_o    <= MemWrite_i;
                mem_addr_o  <= ALUResult_i;
                mem_wdata_o <= RTdata_i;
            end else if (done || abort) begin
                state     <= IDLE;
                mem_req_o <= 1'b0;
            end else if (state == ACCESS) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

    mem_wb_reg u_mem_wb_reg (
        .clk           (clk_i),
        .rst_n         (rst_i),
        .bubble        (wb_bubble),
        .ctrl          (wb_ctrl),
        .read_data     (wb_rdata),
        .alu_result    (ALUResult_i),
        .rd_addr       (RDaddr_i),
        .wb_reg_write  (RegWrite_o),
        .wb_mem_to_reg (MemtoReg_o),
        .wb_read_data  (ReadData_o),
        .wb_alu_result (ALUResult_o),
        .wb_rd_addr    (RDaddr_o)
    );

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: self-checking bench for mem_stage (MAX_WAIT = 4).
// Expected MEM/WB entries go into a queue when an instruction is issued
// and are popped whenever the MEM/WB register shows a non-empty slot.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic [31:0] sum_i = '0;
    logic [31:0] ALUResult_i = '0;
    logic        zero_i = 1'b0;
    logic [31:0] RTdata_i = '0;
    logic [4:0]  RDaddr_i = '0;
    logic        Branch_i = 1'b0;
    logic        MemRead_i = 1'b0;
    logic        MemWrite_i = 1'b0;
    logic        RegWrite_i = 1'b0;
    logic        MemtoReg_i = 1'b0;
    logic        PCSrc_o;
    logic [31:0] branch_target_o;
    logic        stall_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        RegWrite_o;
    logic        MemtoReg_o;
    logic [31:0] ReadData_o;
    logic [31:0] ALUResult_o;
    logic [4:0]  RDaddr_o;
    logic        err_o;

    int n_cmp = 0;
    int n_bad = 0;

    // {RegWrite, MemtoReg, ReadData, ALUResult, RDaddr}
    logic [70:0] sb_q[$];

    always #5 clk = ~clk;

    mem_stage #(.MAX_WAIT(4)) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .sum_i           (sum_i),
        .ALUResult_i     (ALUResult_i),
        .zero_i          (zero_i),
        .RTdata_i        (RTdata_i),
        .RDaddr_i        (RDaddr_i),
        .Branch_i        (Branch_i),
        .MemRead_i       (MemRead_i),
        .MemWrite_i      (MemWrite_i),
        .RegWrite_i      (RegWrite_i),
        .MemtoReg_i      (MemtoReg_i),
        .PCSrc_o         (PCSrc_o),
        .branch_target_o (branch_target_o),
        .stall_o         (stall_o),
        .mem_req_o       (mem_req_o),
        .mem_we_o        (mem_we_o),
        .mem_addr_o      (mem_addr_o),
        .mem_wdata_o     (mem_wdata_o),
        .mem_ack_i       (mem_ack_i),
        .mem_rdata_i     (mem_rdata_i),
        .RegWrite_o      (RegWrite_o),
        .MemtoReg_o      (MemtoReg_o),
        .ReadData_o      (ReadData_o),
        .ALUResult_o     (ALUResult_o),
        .RDaddr_o        (RDaddr_o),
        .err_o           (err_o)
    );

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor: any non-zero MEM/WB slot must match the queue head.
    always @(negedge clk) begin
        logic [70:0] obs;
        obs = {RegWrite_o, MemtoReg_o, ReadData_o, ALUResult_o, RDaddr_o};
        if (obs != '0) begin
            if (sb_q.size() == 0) begin
                chk("wb_unexpected", {1'b0, obs}, 72'd0);
            end else begin
                chk("wb_entry", {1'b0, obs}, {1'b0, sb_q.pop_front()});
            end
        end
    end

    task automatic drive_nop();
        Branch_i    = 1'b0;
        zero_i      = 1'b0;
        sum_i       = '0;
        MemRead_i   = 1'b0;
        MemWrite_i  = 1'b0;
        RegWrite_i  = 1'b0;
        MemtoReg_i  = 1'b0;
        ALUResult_i = '0;
        RTdata_i    = '0;
        RDaddr_i    = '0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive_nop();
        rst_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_i = 1'b1;
    endtask

    // Issue one instruction; ack_at = ACCESS cycle (1-based) carrying the
    // ack, 0 = never ack. Returns the observed stall and request cycle counts.
    task automatic issue(input logic rd, input logic wr, input logic rw, input logic m2r,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [4:0] rdad, input int ack_at,
                         input logic [31:0] rdata, input logic expect_wb,
                         output int stalls, output int reqs);
        bit finished;
        @(negedge clk);
        drive_nop();
        MemRead_i   = rd;
        MemWrite_i  = wr;
        RegWrite_i  = rw;
        MemtoReg_i  = m2r;
        ALUResult_i = addr;
        RTdata_i    = wdata;
        RDaddr_i    = rdad;
        if (expect_wb) begin
            sb_q.push_back({rw, m2r, (rd ? rdata : 32'd0), addr, rdad});
        end
        stalls   = 0;
        reqs     = 0;
        finished = 1'b0;
        for (int c = 0; c < 300; c++) begin
            mem_ack_i   = (c > 0) && (c == ack_at);
            mem_rdata_i = mem_ack_i ? rdata : 32'd0;
            #1;
            if (stall_o) stalls++;
            if (mem_req_o) begin
                reqs++;
                chk("mem_addr", {40'd0, mem_addr_o}, {40'd0, addr});
                chk("mem_we", {71'd0, mem_we_o}, {71'd0, wr});
                chk("mem_wdata", {40'd0, mem_wdata_o}, {40'd0, wdata});
            end
            if (!stall_o) begin
                finished = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!finished) chk("issue_bound", 72'd0, 72'd1);
        @(negedge clk);
        drive_nop();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int rq;

        // Reset state
        drive_nop();
        rst_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_req", {71'd0, mem_req_o}, 72'd0);
        chk("rst_err", {71'd0, err_o}, 72'd0);
        chk("rst_regwrite", {71'd0, RegWrite_o}, 72'd0);
        chk("rst_addr", {40'd0, mem_addr_o}, 72'd0);
        chk("rst_stall", {71'd0, stall_o}, 72'd0);
        rst_i = 1'b1;

        // Plain ALU op
        issue(1'b0, 1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 5'd5, 0, 32'h0, 1'b1, st, rq);
        chk("alu_stalls", 72'(st), 72'd0);
        chk("alu_reqs", 72'(rq), 72'd0);

        // Branch resolution, same cycle
        @(negedge clk);
        Branch_i = 1'b1; zero_i = 1'b1; sum_i = 32'h80;
        #1;
        chk("br_taken", {71'd0, PCSrc_o}, 72'd1);
        chk("br_target", {40'd0, branch_target_o}, 72'h80);
        zero_i = 1'b0;
        #1;
        chk("br_not_taken", {71'd0, PCSrc_o}, 72'd0);
        drive_nop();

        // Load, ack in 3rd ACCESS cycle
        issue(1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 32'h0, 5'd7, 3, 32'hDEADBEEF, 1'b1, st, rq);
        chk("ld3_stalls", 72'(st), 72'd3);
        chk("ld3_reqs", 72'(rq), 72'd3);
        chk("ld3_req_drop", {71'd0, mem_req_o}, 72'd0);
        chk("ld3_m2r", {71'd0, MemtoReg_o}, 72'd1);

        // Store, immediate ack
        issue(1'b0, 1'b1, 1'b0, 1'b0, 32'h200, 32'h12345678, 5'd0, 1, 32'hAAAA5555, 1'b1, st, rq);
        chk("st_stalls", 72'(st), 72'd1);
        chk("st_reqs", 72'(rq), 72'd1);
        chk("st_regwrite", {71'd0, RegWrite_o}, 72'd0);

        // Ack exactly in the timeout cycle: normal completion
        issue(1'b1, 1'b0, 1'b1, 1'b1, 32'h104, 32'h0, 5'd9, 4, 32'h0BADF00D, 1'b1, st, rq);
        chk("late_ack_stalls", 72'(st), 72'd4);
        chk("late_ack_err", {71'd0, err_o}, 72'd0);

        // Misaligned load
        issue(1'b1, 1'b0, 1'b1, 1'b1, 32'h102, 32'h0, 5'd3, 0, 32'h0, 1'b0, st, rq);
        chk("mis_reqs", 72'(rq), 72'd0);
        chk("mis_err", {71'd0, err_o}, 72'd1);
        chk("mis_req", {71'd0, mem_req_o}, 72'd0);

        do_reset();
        @(negedge clk);
        chk("rst_clears_err", {71'd0, err_o}, 72'd0);

        // Illegal read+write
        issue(1'b1, 1'b1, 1'b1, 1'b0, 32'h300, 32'h55, 5'd4, 0, 32'h0, 1'b0, st, rq);
        chk("ill_stalls", 72'(st), 72'd0);
        chk("ill_err", {71'd0, err_o}, 72'd1);
        chk("ill_req", {71'd0, mem_req_o}, 72'd0);

        do_reset();

        // Timeout: never ack
        issue(1'b1, 1'b0, 1'b1, 1'b1, 32'h300, 32'h0, 5'd6, 0, 32'h0, 1'b0, st, rq);
        chk("to_stalls", 72'(st), 72'd4);
        chk("to_reqs", 72'(rq), 72'd4);
        chk("to_err", {71'd0, err_o}, 72'd1);
        chk("to_req_drop", {71'd0, mem_req_o}, 72'd0);

        // Back in IDLE: ALU op flows straight through
        issue(1'b0, 1'b0, 1'b1, 1'b0, 32'h44, 32'h0, 5'd12, 0, 32'h0, 1'b1, st, rq);
        chk("post_to_stalls", 72'(st), 72'd0);

        do_reset();

        // Reset during 2nd ACCESS cycle
        @(negedge clk);
        MemRead_i = 1'b1; RegWrite_i = 1'b1; MemtoReg_i = 1'b1;
        ALUResult_i = 32'h400; RDaddr_i = 5'd8; RTdata_i = 32'h77;
        @(negedge clk);
        @(negedge clk);
        chk("mid_req_before", {71'd0, mem_req_o}, 72'd1);
        drive_nop();
        rst_i = 1'b0;
        @(negedge clk);
        chk("mid_req", {71'd0, mem_req_o}, 72'd0);
        chk("mid_addr", {40'd0, mem_addr_o}, 72'd0);
        chk("mid_wdata", {40'd0, mem_wdata_o}, 72'd0);
        chk("mid_err", {71'd0, err_o}, 72'd0);
        chk("mid_wb", {1'b0, RegWrite_o, MemtoReg_o, ReadData_o, ALUResult_o, RDaddr_o}, 72'd0);
        rst_i = 1'b1;
        mem_ack_i = 1'b1;
        mem_rdata_i = 32'hFFFF_0000;
        #1;
        chk("late_ack_stall", {71'd0, stall_o}, 72'd0);
        @(negedge clk);
        chk("late_ack_req", {71'd0, mem_req_o}, 72'd0);
        chk("late_ack_wb", {71'd0, RegWrite_o}, 72'd0);
        drive_nop();
        @(negedge clk);

        chk("sb_empty", 72'(sb_q.size()), 72'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
